// File: rtl/thresh_pkg.sv
// Shared definitions for the frame-mean threshold path: state encodings,
// accumulator sizing and pass bookkeeping reused by the FIFO read controller.
package thresh_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_APPLY  = 2'd2
  } state_e;

  // Each frame is read twice: once to accumulate, once to binarise.
  localparam int unsigned PASS_COUNT = 2;
  localparam int unsigned PASS_ACCUM = 0;
  localparam int unsigned PASS_APPLY = 1;

  // Accumulator wide enough for num_pixels full-scale pixels without overflow.
  function automatic int unsigned sum_width(input int unsigned data_width,
                                            input int unsigned num_pixels);
    return data_width + $clog2(num_pixels);
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses exactly
// SUM_WIDTH cycles after start (the first bit is produced on the start edge).
module serial_divider #(
  parameter int unsigned SUM_WIDTH     = 10,
  parameter int unsigned DIVISOR_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SUM_WIDTH-1:0]     dividend,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic                     busy,
  output logic                     done,
  output logic [SUM_WIDTH-1:0]     quotient
);

  localparam int unsigned CNT_WIDTH = $clog2(SUM_WIDTH + 1);

  logic [DIVISOR_WIDTH-1:0] rem_q, rem_n, src_rem;
  logic [SUM_WIDTH-1:0]     dvd_q, dvd_n, src_dvd, src_quot, quot_n;
  logic [DIVISOR_WIDTH:0]   trial;
  logic                     ge;
  logic [CNT_WIDTH-1:0]     cnt_q;

  // One restoring step, seeded from the operands on start.
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_dvd  = start ? dividend : dvd_q;
    src_quot = start ? '0 : quotient;
    trial    = {src_rem, src_dvd[SUM_WIDTH-1]};
    ge       = trial >= {1'b0, divisor};
    rem_n    = ge ? DIVISOR_WIDTH'(trial - {1'b0, divisor}) : DIVISOR_WIDTH'(trial);
    quot_n   = {src_quot[SUM_WIDTH-2:0], ge};
    dvd_n    = {src_dvd[SUM_WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q    <= '0;
      dvd_q    <= '0;
      quotient <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= rem_n;
        dvd_q    <= dvd_n;
        quotient <= quot_n;
        cnt_q    <= CNT_WIDTH'(SUM_WIDTH - 1);
        busy     <= 1'b1;
      end else if (busy) begin
        rem_q    <= rem_n;
        dvd_q    <= dvd_n;
        quotient <= quot_n;
        cnt_q    <= cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mean_threshold_unit.sv
// Two-pass frame binariser: pass 1 sums the frame and divides for the mean,
// pass 2 thresholds each pixel against that mean.
module mean_threshold_unit
  import thresh_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PIXELS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic                  bin_out,
  output logic [DATA_WIDTH-1:0] pix_out,
  output logic [DATA_WIDTH-1:0] threshold,
  output logic                  thresh_valid,
  output logic                  frame_done
);

  localparam int unsigned SUM_WIDTH = sum_width(DATA_WIDTH, NUM_PIXELS);
  localparam int unsigned CNT_WIDTH = $clog2(NUM_PIXELS);
  localparam int unsigned DIV_WIDTH = $clog2(NUM_PIXELS + 1);

  state_e                 state;
  logic [SUM_WIDTH-1:0]   sum, sum_next, quotient;
  logic [CNT_WIDTH-1:0]   pix_cnt;
  logic                   xfer, last_pix, div_start, div_busy, div_done;
  logic                   div_unused;

  assign in_ready  = (state == ST_ACCUM) | (state == ST_APPLY);
  assign xfer      = pix_valid & in_ready;
  assign last_pix  = pix_cnt == CNT_WIDTH'(NUM_PIXELS - 1);
  assign sum_next  = sum + SUM_WIDTH'(pix_in);
  // Divider starts on the edge that absorbs the last pass-1 pixel.
  assign div_start = (state == ST_ACCUM) & xfer & last_pix;

  // The mean of DATA_WIDTH-bit pixels always fits in DATA_WIDTH bits.
  assign div_unused = ^{div_busy, quotient[SUM_WIDTH-1:DATA_WIDTH]};

  serial_divider #(
    .SUM_WIDTH     (SUM_WIDTH),
    .DIVISOR_WIDTH (DIV_WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (sum_next),
    .divisor  (DIV_WIDTH'(NUM_PIXELS)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_ACCUM;
      sum          <= '0;
      pix_cnt      <= '0;
      out_valid    <= 1'b0;
      bin_out      <= 1'b0;
      pix_out      <= '0;
      threshold    <= '0;
      thresh_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (xfer) begin
            sum <= sum_next;
            if (last_pix) begin
              pix_cnt      <= '0;
              thresh_valid <= 1'b0;
              state        <= ST_DIVIDE;
            end else begin
              pix_cnt <= pix_cnt + CNT_WIDTH'(1);
            end
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            threshold    <= quotient[DATA_WIDTH-1:0];
            thresh_valid <= 1'b1;
            state        <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (xfer) begin
            out_valid <= 1'b1;
            bin_out   <= pix_in >= threshold;
            pix_out   <= (pix_in >= threshold) ? '1 : '0;
            if (last_pix) begin
              frame_done   <= 1'b1;
              thresh_valid <= 1'b0;
              sum          <= '0;
              pix_cnt      <= '0;
              state        <= ST_ACCUM;
            end else begin
              pix_cnt <= pix_cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mean_threshold_unit.sv
// Scoreboard bench: a frame-level mean model predicts each pass-2 output,
// and an independent negedge monitor checks whatever the DUT presents.
module tb_mean_threshold_unit;

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 4;
  localparam int unsigned SW = DW + $clog2(NP);

  logic          clk = 1'b0;
  logic          reset, pix_valid, in_ready, out_valid, bin_out, thresh_valid, frame_done;
  logic [DW-1:0] pix_in, pix_out, threshold;

  typedef struct {
    logic          bin;
    logic [DW-1:0] pix;
    logic          fd;
    logic [DW-1:0] thr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mean_threshold_unit #(.DATA_WIDTH(DW), .NUM_PIXELS(NP)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix_in       (pix_in),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .bin_out      (bin_out),
    .pix_out      (pix_out),
    .threshold    (threshold),
    .thresh_valid (thresh_valid),
    .frame_done   (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop one prediction per presented output.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && frame_done && !out_valid) check("frame_done_alone", frame_done, 0);
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check("bin_out", bin_out, e.bin);
        check("pix_out", pix_out, e.pix);
        check("frame_done", frame_done, e.fd);
        check("threshold_at_output", threshold, e.thr);
        if (e.fd) check("thresh_valid_at_frame_done", thresh_valid, 0);
      end
    end
  end

  task automatic send(input logic [DW-1:0] v, output int stalls);
    stalls = 0;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = v;
    while (!in_ready && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_in    = DW'($urandom);
  endtask

  task automatic gap(input int gmax);
    repeat ($urandom_range(0, gmax)) @(negedge clk);
  endtask

  // Sends one pass-1 frame and n2 pass-2 pixels; predicts from the frame mean.
  task automatic run_frame(input logic [DW-1:0] p1[NP], input logic [DW-1:0] p2[NP],
                           input int n2, input int gmax, input bit chk_stall);
    int   sum, thr, st;
    exp_t e;
    sum = 0;
    for (int i = 0; i < NP; i++) sum += int'(p1[i]);
    thr = sum / NP;
    for (int i = 0; i < NP; i++) begin
      gap(gmax);
      send(p1[i], st);
    end
    for (int i = 0; i < n2; i++) begin
      if (!(chk_stall && i == 0)) gap(gmax);
      e.bin = int'(p2[i]) >= thr;
      e.pix = e.bin ? {DW{1'b1}} : '0;
      e.fd  = (i == NP - 1);
      e.thr = DW'(thr);
      sb.push_back(e);
      send(p2[i], st);
      if (i == 0) begin
        if (chk_stall) check("divide_stall_cycles", st, SW);
        check("thresh_valid_in_apply", thresh_valid, 1);
        check("threshold", threshold, thr);
      end
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    #2;
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_bin_out"}, bin_out, 0);
    check({tag, "_pix_out"}, pix_out, 0);
    check({tag, "_thresh_valid"}, thresh_valid, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin : stim
    logic [DW-1:0] a[NP];
    logic [DW-1:0] b[NP];
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_in    = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_threshold", threshold, 0);
    reset = 1'b0;

    a = '{10, 20, 30, 40};
    run_frame(a, a, NP, 0, 1'b1);
    drain();

    a = '{255, 255, 255, 255};
    run_frame(a, a, NP, 0, 1'b1);
    a = '{0, 0, 0, 0};
    run_frame(a, a, NP, 0, 1'b1);
    drain();

    a = '{1, 1, 1, 2};
    b = '{1, 0, 1, 0};
    run_frame(a, b, NP, 1, 1'b1);
    drain();

    // Back-to-back random frames with random gaps.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NP; i++) a[i] = DW'($urandom_range(0, 255));
      for (int i = 0; i < NP; i++) b[i] = DW'($urandom_range(0, 255));
      b[$urandom_range(0, NP - 1)] = a[$urandom_range(0, NP - 1)];
      run_frame(a, b, NP, (f % 2 == 0) ? 0 : 3, 1'b0);
    end
    drain();

    // Reset after two pass-2 pixels, then a fresh frame.
    a = '{100, 200, 50, 150};
    b = '{130, 120, 0, 0};
    run_frame(a, b, 2, 1, 1'b0);
    drain();
    reset = 1'b1;
    #1;
    check_idle("midreset");
    check("midreset_threshold", threshold, 0);
    @(negedge clk);
    reset = 1'b0;
    a = '{8, 8, 8, 9};
    b = '{8, 7, 9, 8};
    run_frame(a, b, NP, 0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
